// File: rtl/stack_macro_sequencer_pkg.sv
// Shared encodings for the stack macro sequencer: SuperStack op/status codes,
// CPU-side command codes, FSM states and the sequence ROM entry layout.
// Optional macro STACK_SEQ_ROT_EN widens the step counter to cover ROT's five primitives.
package stack_macro_sequencer_pkg;

    // SuperStack primitive ops
    localparam logic [2:0] OP_NONE    = 3'd0;
    localparam logic [2:0] OP_PUSH    = 3'd1;
    localparam logic [2:0] OP_POP     = 3'd2;
    localparam logic [2:0] OP_REPLACE = 3'd3;

    // SuperStack status codes, plus the sequencer's own ILLEGAL code
    localparam logic [2:0] ST_NONE       = 3'd0;
    localparam logic [2:0] ST_UNDERFLOW  = 3'd1;
    localparam logic [2:0] ST_OVERFLOW   = 3'd2;
    localparam logic [2:0] ST_BAD_OFFSET = 3'd3;
    localparam logic [2:0] ST_EMPTY      = 3'd4;
    localparam logic [2:0] ST_FULL       = 3'd5;
    localparam logic [2:0] ERR_ILLEGAL   = 3'd7;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_PUSH = 3'd1,
        CMD_DROP = 3'd2,
        CMD_DUP  = 3'd3,
        CMD_OVER = 3'd4,
        CMD_SWAP = 3'd5,
        CMD_ROT  = 3'd6,
        CMD_RSVD = 3'd7
    } cmd_e;

    // Source of the data word that accompanies a primitive op
    typedef enum logic [2:0] {
        DSEL_ZERO, DSEL_ARG, DSEL_T0, DSEL_T1, DSEL_T2
    } dsel_e;

    typedef enum logic [1:0] {
        S_IDLE, S_ISSUE, S_CHECK, S_FIN
    } state_t;

`ifdef STACK_SEQ_ROT_EN
    localparam int STEP_W = 3;
`else
    localparam int STEP_W = 2;
`endif

    typedef struct packed {
        logic [2:0] op;
        dsel_e      dsel;
        logic       last;
    } rom_t;

    // Statuses that abort the remaining steps of a sequence
    function automatic logic is_abort_status(input logic [2:0] st);
        return (st == ST_UNDERFLOW) || (st == ST_OVERFLOW) || (st == ST_BAD_OFFSET);
    endfunction

endpackage

// File: rtl/stack_macro_sequencer_rom.sv
// stack_seq_rom: maps (latched command, step) to the primitive op, its data source and a last flag.
// Latency: purely combinational. Backpressure: none, the FSM in the top decides when to advance.
// Ports: cmd_i latched command, step_i step index, drop_last_i final step of DROP n (n-1), rom_o entry.
// ROT entries exist only when STACK_SEQ_ROT_EN is defined.
module stack_seq_rom
    import stack_macro_sequencer_pkg::*;
(
    input  logic [2:0]        cmd_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic [STEP_W-1:0] drop_last_i,
    output rom_t              rom_o
);

    always_comb begin
        rom_o = '{OP_NONE, DSEL_ZERO, 1'b1};
        case (cmd_e'(cmd_i))
            CMD_PUSH: rom_o = '{OP_PUSH, DSEL_ARG, 1'b1};
            CMD_DROP: rom_o = '{OP_POP, DSEL_ZERO, (step_i == drop_last_i)};
            CMD_DUP:  rom_o = '{OP_PUSH, DSEL_T0, 1'b1};
            CMD_OVER: rom_o = '{OP_PUSH, DSEL_T1, 1'b1};
            CMD_SWAP: begin
                if (step_i == STEP_W'(0))      rom_o = '{OP_POP, DSEL_ZERO, 1'b0};
                else if (step_i == STEP_W'(1)) rom_o = '{OP_REPLACE, DSEL_T0, 1'b0};
                else                           rom_o = '{OP_PUSH, DSEL_T1, 1'b1};
            end
`ifdef STACK_SEQ_ROT_EN
            // t2 t1 t0 -> t1 t0 t2: strip two, overwrite t2 with t1, then rebuild
            CMD_ROT: begin
                if (step_i == STEP_W'(0))      rom_o = '{OP_POP, DSEL_ZERO, 1'b0};
                else if (step_i == STEP_W'(1)) rom_o = '{OP_POP, DSEL_ZERO, 1'b0};
                else if (step_i == STEP_W'(2)) rom_o = '{OP_REPLACE, DSEL_T1, 1'b0};
                else if (step_i == STEP_W'(3)) rom_o = '{OP_PUSH, DSEL_T0, 1'b0};
                else                           rom_o = '{OP_PUSH, DSEL_T2, 1'b1};
            end
`endif
            default: rom_o = '{OP_NONE, DSEL_ZERO, 1'b1};
        endcase
    end

endmodule

// File: rtl/stack_macro_sequencer.sv
// stack_macro_sequencer: expands CPU stack commands into SuperStack primitive op sequences.
// Latency: 2 cycles accept-to-done for zero-op commands, 2k+1 cycles for k primitives.
// Backpressure: cmd_ready_o is high only in IDLE; one command in flight at a time.
// Ports: cmd_* CPU request, done_o/error_o/err_code_o completion, stk_* SuperStack op/data/status.
// Optional macro STACK_SEQ_ROT_EN enables ROT; otherwise ROT is rejected as ILLEGAL.
module stack_macro_sequencer
    import stack_macro_sequencer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       cmd_i,
    input  logic [WIDTH-1:0] cmd_arg_i,
    output logic             done_o,
    output logic             error_o,
    output logic [2:0]       err_code_o,
    input  logic [DEPTH:0]   stk_limit_i,
    output logic [2:0]       stk_op_o,
    output logic [WIDTH-1:0] stk_data_o,
    input  logic [DEPTH:0]   stk_index_i,
    input  logic [WIDTH-1:0] stk_out_i,
    input  logic [WIDTH-1:0] stk_out1_i,
    input  logic [WIDTH-1:0] stk_out2_i,
    input  logic [2:0]       stk_status_i
);

    localparam int IW = DEPTH + 1;
    // Precheck arithmetic is wide enough for a full cmd_arg count and index+1
    localparam int CW = ((WIDTH > IW) ? WIDTH : IW) + 1;
    localparam logic [CW-1:0] MAX_STACK = CW'((1 << IW) - 1);

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [STEP_W-1:0] drop_last_q, drop_last_d;
    logic [2:0]        cmd_q, cmd_d;
    logic [WIDTH-1:0]  arg_q, arg_d;
    logic [WIDTH-1:0]  t0_q, t0_d, t1_q, t1_d;
    logic              err_q, err_d;
    logic [2:0]        code_q, code_d;
    logic              skip_q, skip_d;   // no primitives: pass straight through CHECK to FIN
    rom_t              rom;

`ifdef STACK_SEQ_ROT_EN
    logic [WIDTH-1:0]  t2_q, t2_d;
`else
    logic              unused_out2;
    assign unused_out2 = ^stk_out2_i;
`endif

    stack_seq_rom u_rom (
        .cmd_i       (cmd_q),
        .step_i      (step_q),
        .drop_last_i (drop_last_q),
        .rom_o       (rom)
    );

    // Precheck on the live stack before anything is issued
    logic [CW-1:0] idx_w, lim_w, live, need, grow;
    logic          pre_ill, pre_zero, pre_uf, pre_of;

    always_comb begin
        idx_w    = CW'(stk_index_i);
        lim_w    = CW'(stk_limit_i);
        live     = (idx_w >= lim_w) ? (idx_w - lim_w) : '0;
        need     = '0;
        grow     = '0;
        pre_ill  = 1'b0;
        pre_zero = 1'b0;
        case (cmd_e'(cmd_i))
            CMD_NOP:  pre_zero = 1'b1;
            CMD_PUSH: grow = CW'(1);
            CMD_DROP: begin
                need     = CW'(cmd_arg_i);
                pre_zero = (cmd_arg_i == '0);
            end
            CMD_DUP:  begin need = CW'(1); grow = CW'(1); end
            CMD_OVER: begin need = CW'(2); grow = CW'(1); end
            CMD_SWAP: need = CW'(2);
`ifdef STACK_SEQ_ROT_EN
            CMD_ROT:  need = CW'(3);
`endif
            default:  pre_ill = 1'b1;
        endcase
        pre_uf = (live < need);
        pre_of = ((idx_w + grow) > MAX_STACK);
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        drop_last_d = drop_last_q;
        cmd_d       = cmd_q;
        arg_d       = arg_q;
        t0_d        = t0_q;
        t1_d        = t1_q;
`ifdef STACK_SEQ_ROT_EN
        t2_d        = t2_q;
`endif
        err_d       = err_q;
        code_d      = code_q;
        skip_d      = skip_q;
        cmd_ready_o = 1'b0;
        done_o      = 1'b0;
        error_o     = 1'b0;
        err_code_o  = ST_NONE;
        stk_op_o    = OP_NONE;
        stk_data_o  = '0;

        case (state_q)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    cmd_d       = cmd_i;
                    arg_d       = cmd_arg_i;
                    t0_d        = stk_out_i;
                    t1_d        = stk_out1_i;
`ifdef STACK_SEQ_ROT_EN
                    t2_d        = stk_out2_i;
`endif
                    step_d      = '0;
                    drop_last_d = STEP_W'(cmd_arg_i - WIDTH'(1));
                    err_d       = pre_ill | pre_uf | pre_of;
                    if (pre_ill)     code_d = ERR_ILLEGAL;
                    else if (pre_uf) code_d = ST_UNDERFLOW;
                    else if (pre_of) code_d = ST_OVERFLOW;
                    else             code_d = ST_NONE;
                    skip_d      = pre_ill | pre_uf | pre_of | pre_zero;
                    state_d     = (pre_ill | pre_uf | pre_of | pre_zero) ? S_CHECK : S_ISSUE;
                end
            end
            S_ISSUE: begin
                stk_op_o = rom.op;
                case (rom.dsel)
                    DSEL_ARG: stk_data_o = arg_q;
                    DSEL_T0:  stk_data_o = t0_q;
                    DSEL_T1:  stk_data_o = t1_q;
`ifdef STACK_SEQ_ROT_EN
                    DSEL_T2:  stk_data_o = t2_q;
`endif
                    default:  stk_data_o = '0;
                endcase
                state_d = S_CHECK;
            end
            S_CHECK: begin
                // stk_status_i here reflects the op registered on the previous edge
                if (skip_q) begin
                    state_d = S_FIN;
                end else if (is_abort_status(stk_status_i)) begin
                    err_d   = 1'b1;
                    code_d  = stk_status_i;
                    state_d = S_FIN;
                end else if (rom.last) begin
                    state_d = S_FIN;
                end else begin
                    step_d  = step_q + STEP_W'(1);
                    state_d = S_ISSUE;
                end
            end
            S_FIN: begin
                done_o     = 1'b1;
                error_o    = err_q;
                err_code_o = err_q ? code_q : ST_NONE;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            drop_last_q <= '0;
            cmd_q       <= '0;
            arg_q       <= '0;
            t0_q        <= '0;
            t1_q        <= '0;
`ifdef STACK_SEQ_ROT_EN
            t2_q        <= '0;
`endif
            err_q       <= 1'b0;
            code_q      <= ST_NONE;
            skip_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            drop_last_q <= drop_last_d;
            cmd_q       <= cmd_d;
            arg_q       <= arg_d;
            t0_q        <= t0_d;
            t1_q        <= t1_d;
`ifdef STACK_SEQ_ROT_EN
            t2_q        <= t2_d;
`endif
            err_q       <= err_d;
            code_q      <= code_d;
            skip_q      <= skip_d;
        end
    end

endmodule

// File: tb/tb_stack_macro_sequencer.sv
// Bench for stack_macro_sequencer: hosts a behavioural SuperStack (WIDTH=8, DEPTH=1),
// predicts each command's outcome from a queue-based stack model and checks it at done.
module tb_stack_macro_sequencer;
    import stack_macro_sequencer_pkg::*;

    localparam int MAXS = 3;
`ifdef STACK_SEQ_ROT_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, cmd_valid, cmd_ready, done, error;
    logic [2:0] cmd, err_code, stk_op, stk_status;
    logic [7:0] cmd_arg, stk_data, stk_out, stk_out1, stk_out2;
    logic [1:0] stk_limit, stk_index;

    stack_macro_sequencer #(.WIDTH(8), .DEPTH(1)) dut (
        .clk_i(clk), .reset_i(reset), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_i(cmd), .cmd_arg_i(cmd_arg), .done_o(done), .error_o(error), .err_code_o(err_code),
        .stk_limit_i(stk_limit), .stk_op_o(stk_op), .stk_data_o(stk_data), .stk_index_i(stk_index),
        .stk_out_i(stk_out), .stk_out1_i(stk_out1), .stk_out2_i(stk_out2), .stk_status_i(stk_status)
    );

    // ---------------- behavioural SuperStack ----------------
    logic [7:0] mem [0:3];
    int         cnt = 0;
    logic [2:0] st  = ST_EMPTY;

    function automatic logic [2:0] fill(input int n);
        return (n == 0) ? ST_EMPTY : (n == MAXS) ? ST_FULL : ST_NONE;
    endfunction

    always @(posedge clk) begin
        case (stk_op)
            OP_PUSH: if (cnt >= MAXS) st <= ST_OVERFLOW;
                     else begin mem[cnt] <= stk_data; cnt <= cnt + 1; st <= fill(cnt + 1); end
            OP_POP:  if (cnt <= int'(stk_limit)) st <= ST_UNDERFLOW;
                     else begin cnt <= cnt - 1; st <= fill(cnt - 1); end
            OP_REPLACE: if (cnt == 0 || cnt <= int'(stk_limit)) st <= ST_UNDERFLOW;
                     else begin mem[cnt-1] <= stk_data; st <= fill(cnt); end
            default: st <= fill(cnt);
        endcase
    end

    assign stk_index  = 2'(cnt);
    assign stk_out    = (cnt > 0) ? mem[cnt-1] : 8'h00;
    assign stk_out1   = (cnt > 1) ? mem[cnt-2] : 8'h00;
    assign stk_out2   = (cnt > 2) ? mem[cnt-3] : 8'h00;
    assign stk_status = st;

    // ---------------- checking infrastructure ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       err;
        logic [2:0] code;
        int         lat;
        int         ops;
        int         idx;
        logic [7:0] o0, o1, o2;
        logic [2:0] st;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] ref_q [$];   // reference stack, top at the back

    // Reference: what a CPU-level stack command should do to the stack and report
    task automatic ref_cmd(input logic [2:0] c, input logic [7:0] a, output exp_t e);
        int s, live, need, grow, k, n;
        logic ill;
        logic [7:0] x, y, z;
        s = ref_q.size();
        live = (s >= int'(stk_limit)) ? s - int'(stk_limit) : 0;
        need = 0; grow = 0; k = 0; ill = 1'b0;
        case (c)
            3'd1: begin grow = 1; k = 1; end
            3'd2: begin need = int'(a); k = int'(a); end
            3'd3: begin need = 1; grow = 1; k = 1; end
            3'd4: begin need = 2; grow = 1; k = 1; end
            3'd5: begin need = 2; k = 3; end
            3'd6: if (ROT_EN) begin need = 3; k = 5; end else ill = 1'b1;
            3'd7: ill = 1'b1;
            default: k = 0;
        endcase
        e.err = 1'b1;
        if (ill)                    begin e.code = ERR_ILLEGAL;  k = 0; end
        else if (live < need)       begin e.code = ST_UNDERFLOW; k = 0; end
        else if (s + grow > MAXS)   begin e.code = ST_OVERFLOW;  k = 0; end
        else begin
            e.err = 1'b0; e.code = ST_NONE;
            case (c)
                3'd1: ref_q.push_back(a);
                3'd2: for (int i = 0; i < int'(a); i++) x = ref_q.pop_back();
                3'd3: ref_q.push_back(ref_q[s-1]);
                3'd4: ref_q.push_back(ref_q[s-2]);
                3'd5: begin x = ref_q[s-1]; ref_q[s-1] = ref_q[s-2]; ref_q[s-2] = x; end
                3'd6: begin
                    x = ref_q[s-3]; y = ref_q[s-2]; z = ref_q[s-1];
                    ref_q[s-3] = y; ref_q[s-2] = z; ref_q[s-1] = x;
                end
                default: ;
            endcase
        end
        e.ops = k;
        e.lat = (k == 0) ? 2 : 2 * k + 1;
        n = ref_q.size();
        e.idx = n;
        e.o0 = (n > 0) ? ref_q[n-1] : 8'h00;
        e.o1 = (n > 1) ? ref_q[n-2] : 8'h00;
        e.o2 = (n > 2) ? ref_q[n-3] : 8'h00;
        e.st = fill(n);
    endtask

    // ---------------- monitor ----------------
    int cyc = 0;
    int acc_edge = 0;
    int ops_seen = 0;
    int done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (cmd_valid && cmd_ready) begin
                acc_edge = cyc + 1;
                ops_seen = 0;
            end
            if (stk_op != OP_NONE) ops_seen++;
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("error",    32'(error),    32'(e.err));
                    check("err_code", 32'(err_code), 32'(e.code));
                    check("latency",  32'(cyc - acc_edge + 1), 32'(e.lat));
                    check("op_count", 32'(ops_seen), 32'(e.ops));
                    check("index",    32'(stk_index), 32'(e.idx));
                    check("out",      32'(stk_out),  32'(e.o0));
                    check("out1",     32'(stk_out1), 32'(e.o1));
                    check("out2",     32'(stk_out2), 32'(e.o2));
                    check("status",   32'(stk_status), 32'(e.st));
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_cmd(input logic [2:0] c, input logic [7:0] a);
        exp_t e;
        int t, d0;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        if (t >= 50) check("ready_timeout", 32'd0, 32'd1);
        ref_cmd(c, a, e);
        exp_q.push_back(e);
        d0 = done_cnt;
        cmd = c; cmd_arg = a; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        t = 0;
        while (done_cnt == d0 && t < 60) begin @(negedge clk); t++; end
        if (done_cnt == d0) begin
            check("done_timeout", 32'd0, 32'd1);
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    // Reset while the second POP of a sequence is on the bus
    task automatic reset_mid;
        int pops, t;
        logic [7:0] x;
        cmd = ROT_EN ? 3'd6 : 3'd2; cmd_arg = 8'd2; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        pops = 0; t = 0;
        while (pops < 2 && t < 40) begin
            @(negedge clk);
            if (stk_op == OP_POP) pops++;
            t++;
        end
        if (pops < 2) check("reset_pop_timeout", 32'd0, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        // the stack itself still executes both POPs
        x = ref_q.pop_back();
        x = ref_q.pop_back();
        @(negedge clk);
        check("rst_mid_ready", 32'(cmd_ready), 32'd1);
        check("rst_mid_op",    32'(stk_op),    32'(OP_NONE));
        check("rst_mid_done",  32'(done),      32'd0);
        repeat (8) @(negedge clk);
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0] c;
        logic [7:0] a;
        reset = 1'b1; cmd_valid = 1'b0; cmd = 3'd0; cmd_arg = 8'd0; stk_limit = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready",    32'(cmd_ready),  32'd1);
        check("rst_done",     32'(done),       32'd0);
        check("rst_error",    32'(error),      32'd0);
        check("rst_err_code", 32'(err_code),   32'(ST_NONE));
        check("rst_stk_op",   32'(stk_op),     32'(OP_NONE));
        check("rst_stk_data", 32'(stk_data),   32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        do_cmd(3'd1, 8'h11);  do_cmd(3'd1, 8'h22);  do_cmd(3'd3, 8'h00);  // DUP -> full
        do_cmd(3'd2, 8'd3);
        do_cmd(3'd1, 8'h11);  do_cmd(3'd1, 8'h22);  do_cmd(3'd5, 8'h00);  // SWAP
        do_cmd(3'd2, 8'd2);
        do_cmd(3'd1, 8'h0A);  do_cmd(3'd1, 8'h0B);  do_cmd(3'd1, 8'h0C);
        do_cmd(3'd6, 8'h00);                                            // ROT
        do_cmd(3'd1, 8'h44);                                            // overflow
        do_cmd(3'd2, 8'd3);                                             // to empty
        do_cmd(3'd1, 8'h05);  do_cmd(3'd5, 8'h00);                      // SWAP underflow
        do_cmd(3'd1, 8'h06);
        stk_limit = 2'd1;
        do_cmd(3'd2, 8'd2);                                             // underflow above limit
        stk_limit = 2'd0;
        do_cmd(3'd2, 8'd200);                                           // oversized count
        do_cmd(3'd7, 8'h00);                                            // illegal
        do_cmd(3'd0, 8'h00);                                            // NOP
        do_cmd(3'd2, 8'd0);                                             // DROP 0
        do_cmd(3'd1, 8'h07);
        reset_mid();
        do_cmd(3'd0, 8'h00);

        for (int i = 0; i < 60; i++) begin
            stk_limit = 2'($urandom_range(0, 1));
            c = 3'($urandom_range(0, 7));
            if (c == 3'd2)
                a = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
            else
                a = 8'($urandom_range(0, 255));
            do_cmd(c, a);
        end

        repeat (4) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
